// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between instruction fetch
// and the data cache refill/writeback path. Data wins over fetch, but a
// fetch that has waited through STARVE_LIMIT data grants is served next.
// Transactions run IDLE -> SERVE -> ACK, so at most one completes every three
// cycles. stall stays high while any requester is waiting for its ack.
//
// Optional feature: define ARB_TIMEOUT_EN to add a SERVE watchdog. The
// transaction is aborted after TIMEOUT consecutive cycles without m_ready.
// The owner then gets 32'hDEADBEEF as its read data and err pulses together
// with its ack. With the macro undefined, SERVE waits for m_ready
// indefinitely and err is tied low.
module mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ready,
  output logic                  err,
  output logic                  stall
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Reject parameter values the arbitration and watchdog logic cannot honour
  if (STARVE_LIMIT < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_arbiter: STARVE_LIMIT and TIMEOUT must both be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;

  state_t        state;
  logic          owner_d;     // 1: data path owns the current transaction
  logic [SW-1:0] starve_cnt;  // consecutive data grants made while fetch waited
  logic          starve_hit;
  logic          grant_d;

`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;
  logic          err_r;
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  // Data has priority unless the fetch side has hit its starvation limit
  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
  assign grant_d    = d_req & ~(i_req & starve_hit);

  // Stall while either requester has an outstanding, unacknowledged request
  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  // Arbitration FSM with registered memory-side and requester-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt     <= '0;
      err_r      <= 1'b0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d <= grant_d;
            m_req   <= 1'b1;
            state   <= SERVE;
`ifdef ARB_TIMEOUT_EN
            wd_cnt  <= '0;
`endif
            if (grant_d) begin
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              // Only a data grant that bypasses a waiting fetch counts
              if (!i_req)
                starve_cnt <= '0;
              else if (!starve_hit)
                starve_cnt <= starve_cnt + SW'(1);
            end else begin
              m_we       <= 1'b0;
              m_addr     <= i_addr;
              m_wdata    <= '0;
              starve_cnt <= '0;
            end
          end
        end
        SERVE: begin
          if (m_ready) begin
            m_req <= 1'b0;
            state <= ACK;
            if (owner_d) d_ack <= 1'b1;
            else         i_ack <= 1'b1;
            // Writes complete without touching the owner's read data
            if (!m_we) begin
              if (owner_d) d_rdata <= m_rdata;
              else         i_rdata <= m_rdata;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_cnt == WW'(TIMEOUT - 1)) begin
            m_req <= 1'b0;
            state <= ACK;
            err_r <= 1'b1;
            if (owner_d) begin
              d_ack   <= 1'b1;
              d_rdata <= DATA_WIDTH'(32'hDEADBEEF);
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= DATA_WIDTH'(32'hDEADBEEF);
            end
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
`endif
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
